// File: rtl/crop_window_filter_pkg.sv
// Shared types and constants for the crop window filter.
package crop_window_filter_pkg;

    // Frame tracking state: draining until a start of frame, then cropping.
    typedef enum logic {
        WAIT_SOF = 1'b0,
        ACTIVE   = 1'b1
    } state_e;

    localparam int unsigned FRAME_CNT_W = 16;

endpackage

// File: rtl/crop_pos_counter.sv
// Column/row position tracker with saturation and crop window test.
module crop_pos_counter #(
    parameter int unsigned DIM_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             advance,
    input  logic             sof,
    input  logic             last,
    input  logic [DIM_W-1:0] x0,
    input  logic [DIM_W-1:0] y0,
    input  logic [DIM_W-1:0] w,
    input  logic [DIM_W-1:0] h,
    output logic             in_window,
    output logic             end_of_crop_line
);

    localparam int unsigned    EXT_W   = DIM_W + 1;
    localparam logic [DIM_W-1:0] DIM_MAX = '1;

    logic [DIM_W-1:0] col_q;
    logic [DIM_W-1:0] row_q;
    logic             ovf_q;
    logic [DIM_W-1:0] col_c;
    logic [DIM_W-1:0] row_c;
    logic             ovf_c;
    logic [EXT_W-1:0] x_end;
    logic [EXT_W-1:0] y_end;

    // Position of the beat on the bus; a start-of-frame beat is always (0,0).
    always_comb begin
        col_c = sof ? '0 : col_q;
        row_c = sof ? '0 : row_q;
        ovf_c = sof ? 1'b0 : ovf_q;
    end

    // Window bounds widened by one bit so x0+w / y0+h never wrap.
    always_comb begin
        x_end            = EXT_W'(x0) + EXT_W'(w);
        y_end            = EXT_W'(y0) + EXT_W'(h);
        in_window        = !ovf_c && (w != '0) && (h != '0)
                           && (EXT_W'(col_c) >= EXT_W'(x0)) && (EXT_W'(col_c) < x_end)
                           && (EXT_W'(row_c) >= EXT_W'(y0)) && (EXT_W'(row_c) < y_end);
        end_of_crop_line = (EXT_W'(col_c) == (x_end - EXT_W'(1))) || last;
    end

    // Advance position per beat; beats after column saturation are flagged out of window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
            ovf_q <= 1'b0;
        end else if (advance) begin
            if (last) begin
                col_q <= '0;
                ovf_q <= 1'b0;
                row_q <= (row_c == DIM_MAX) ? row_c : row_c + DIM_W'(1);
            end else begin
                row_q <= row_c;
                if (col_c == DIM_MAX) begin
                    col_q <= col_c;
                    ovf_q <= 1'b1;
                end else begin
                    col_q <= col_c + DIM_W'(1);
                    ovf_q <= ovf_c;
                end
            end
        end
    end

endmodule

// File: rtl/crop_window_filter.sv
// Crops a full-frame AXI4-Stream video input into a FIFO write port.
module crop_window_filter
    import crop_window_filter_pkg::*;
#(
    parameter int unsigned C_S_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned C_DIM_WIDTH          = 12
) (
    input  logic                              S_AXIS_ACLK,
    input  logic                              S_AXIS_ARESETN,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic                              S_AXIS_TVALID,
    output logic                              S_AXIS_TREADY,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
    input  logic                              S_AXIS_TLAST,
    input  logic                              S_AXIS_TUSER,
    input  logic [C_DIM_WIDTH-1:0]            cfg_x_start,
    input  logic [C_DIM_WIDTH-1:0]            cfg_y_start,
    input  logic [C_DIM_WIDTH-1:0]            cfg_width,
    input  logic [C_DIM_WIDTH-1:0]            cfg_height,
    output logic                              wr_en,
    input  logic                              full,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]   data_out,
    output logic                              last_out,
    output logic                              user_out,
    output logic [FRAME_CNT_W-1:0]            frame_cnt,
    output logic                              crop_active
);

    state_e                   state_q;
    state_e                   state_d;
    logic [C_DIM_WIDTH-1:0]   x0_q;
    logic [C_DIM_WIDTH-1:0]   y0_q;
    logic [C_DIM_WIDTH-1:0]   w_q;
    logic [C_DIM_WIDTH-1:0]   h_q;
    logic                     sof_pending_q;
    logic [FRAME_CNT_W-1:0]   frame_cnt_q;
    logic                     accept;
    logic                     sof;
    logic                     advance;
    logic                     in_window;
    logic                     end_of_crop_line;
    logic [C_DIM_WIDTH-1:0]   win_x0;
    logic [C_DIM_WIDTH-1:0]   win_y0;
    logic [C_DIM_WIDTH-1:0]   win_w;
    logic [C_DIM_WIDTH-1:0]   win_h;
    logic                     unused_tstrb;

    assign unused_tstrb = ^S_AXIS_TSTRB;

    // State register.
    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            state_q <= WAIT_SOF;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and state-decoded handshake outputs.
    always_comb begin
        state_d       = state_q;
        S_AXIS_TREADY = 1'b1;
        crop_active   = 1'b0;
        case (state_q)
            WAIT_SOF: begin
                if (S_AXIS_TVALID && S_AXIS_TUSER) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                S_AXIS_TREADY = !full;
                crop_active   = 1'b1;
            end
            default: state_d = WAIT_SOF;
        endcase
    end

    // Beat qualification and window source: live config on the start-of-frame beat.
    always_comb begin
        accept  = S_AXIS_TVALID && S_AXIS_TREADY;
        sof     = accept && S_AXIS_TUSER;
        advance = accept && ((state_q == ACTIVE) || S_AXIS_TUSER);
        win_x0  = sof ? cfg_x_start : x0_q;
        win_y0  = sof ? cfg_y_start : y0_q;
        win_w   = sof ? cfg_width   : w_q;
        win_h   = sof ? cfg_height  : h_q;
    end

    crop_pos_counter #(
        .DIM_W (C_DIM_WIDTH)
    ) u_pos (
        .clk              (S_AXIS_ACLK),
        .rst_n            (S_AXIS_ARESETN),
        .advance          (advance),
        .sof              (sof),
        .last             (S_AXIS_TLAST),
        .x0               (win_x0),
        .y0               (win_y0),
        .w                (win_w),
        .h                (win_h),
        .in_window        (in_window),
        .end_of_crop_line (end_of_crop_line)
    );

    // Zero-latency write path; full also guards the always-ready drain state.
    always_comb begin
        wr_en    = advance && in_window && !full;
        data_out = S_AXIS_TDATA;
        last_out = wr_en && end_of_crop_line;
        user_out = wr_en && (sof || sof_pending_q);
        frame_cnt = frame_cnt_q;
    end

    // Config latch, start-of-frame flag and frame counter.
    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            x0_q          <= '0;
            y0_q          <= '0;
            w_q           <= '0;
            h_q           <= '0;
            sof_pending_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else if (sof) begin
            x0_q          <= cfg_x_start;
            y0_q          <= cfg_y_start;
            w_q           <= cfg_width;
            h_q           <= cfg_height;
            sof_pending_q <= !wr_en;
            frame_cnt_q   <= frame_cnt_q + FRAME_CNT_W'(1);
        end else if (wr_en) begin
            sof_pending_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_crop_window_filter.sv
// Directed and randomized checks of crop_window_filter against a frame-level model.
module tb_crop_window_filter;

    localparam int unsigned DW   = 32;
    localparam int unsigned DIMW = 12;

    typedef struct {
        logic [DW-1:0] d;
        logic          u;
        logic          l;
    } beat_t;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        logic          u;
    } wr_t;

    logic              clk;
    logic              rst_n;
    logic [DW-1:0]     s_tdata;
    logic              s_tvalid;
    logic              s_tready;
    logic [DW/8-1:0]   s_tstrb;
    logic              s_tlast;
    logic              s_tuser;
    logic [DIMW-1:0]   cfg_x_start;
    logic [DIMW-1:0]   cfg_y_start;
    logic [DIMW-1:0]   cfg_width;
    logic [DIMW-1:0]   cfg_height;
    logic              wr_en;
    logic              full;
    logic [DW-1:0]     data_out;
    logic              last_out;
    logic              user_out;
    logic [15:0]       frame_cnt;
    logic              crop_active;

    int vectors;
    int miscompares;
    int exp_frames;

    beat_t stim[$];
    wr_t   exp_q[$];
    wr_t   got_q[$];

    crop_window_filter #(
        .C_S_AXIS_TDATA_WIDTH (DW),
        .C_DIM_WIDTH          (DIMW)
    ) dut (
        .S_AXIS_ACLK    (clk),
        .S_AXIS_ARESETN (rst_n),
        .S_AXIS_TDATA   (s_tdata),
        .S_AXIS_TVALID  (s_tvalid),
        .S_AXIS_TREADY  (s_tready),
        .S_AXIS_TSTRB   (s_tstrb),
        .S_AXIS_TLAST   (s_tlast),
        .S_AXIS_TUSER   (s_tuser),
        .cfg_x_start    (cfg_x_start),
        .cfg_y_start    (cfg_y_start),
        .cfg_width      (cfg_width),
        .cfg_height     (cfg_height),
        .wr_en          (wr_en),
        .full           (full),
        .data_out       (data_out),
        .last_out       (last_out),
        .user_out       (user_out),
        .frame_cnt      (frame_cnt),
        .crop_active    (crop_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture every FIFO write; a write while full is an immediate miscompare.
    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            got_q.push_back('{d: data_out, l: last_out, u: user_out});
            if (full) begin
                miscompares++;
                $error("FAIL write_while_full: observed wr_en=1 expected wr_en=0");
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Builds one frame of beats and, from window geometry alone, the writes it must produce.
    task automatic make_frame(input int rows, input int cols, input int short_row, input int short_len,
                              input bit rnd, input int x0, input int y0, input int w, input int h,
                              input int trunc);
        int n;
        bit first;
        n     = 0;
        first = 1'b1;
        cfg_x_start = DIMW'(x0);
        cfg_y_start = DIMW'(y0);
        cfg_width   = DIMW'(w);
        cfg_height  = DIMW'(h);
        for (int r = 0; r < rows; r++) begin
            int len;
            len = (r == short_row) ? short_len : cols;
            for (int c = 0; c < len; c++) begin
                beat_t b;
                wr_t   e;
                if (trunc >= 0 && n >= trunc) return;
                b.d = rnd ? $urandom : DW'(r * 8 + c);
                b.u = (r == 0 && c == 0);
                b.l = (c == len - 1);
                stim.push_back(b);
                n++;
                if (w > 0 && h > 0 && c >= x0 && c < x0 + w && r >= y0 && r < y0 + h
                    && c < (1 << DIMW)) begin
                    e.d = b.d;
                    e.l = (c == x0 + w - 1) || (c == len - 1);
                    e.u = first;
                    first = 1'b0;
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    // Presents one beat, optionally holding it under FIFO full first.
    task automatic send(input logic [DW-1:0] d, input logic u, input logic l, input int stall);
        s_tdata  = d;
        s_tuser  = u;
        s_tlast  = l;
        s_tvalid = 1'b1;
        for (int i = 0; i < stall; i++) begin
            full = 1'b1;
            @(negedge clk);
            chk("stall_tready", 64'(s_tready), 64'(0));
            chk("stall_wr_en", 64'(wr_en), 64'(0));
            @(posedge clk);
            #1;
        end
        full = 1'b0;
        @(negedge clk);
        chk("beat_tready", 64'(s_tready), 64'(1));
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic play(input int stall_idx, input int stall_n, input bit scramble);
        for (int i = 0; i < stim.size(); i++) begin
            send(stim[i].d, stim[i].u, stim[i].l, (i == stall_idx) ? stall_n : 0);
            if (scramble && stim[i].u) begin
                cfg_x_start = DIMW'($urandom_range(0, 15));
                cfg_y_start = DIMW'($urandom_range(0, 15));
                cfg_width   = DIMW'($urandom_range(0, 15));
                cfg_height  = DIMW'($urandom_range(0, 15));
            end
        end
        stim.delete();
    endtask

    task automatic compare(input string tag);
        chk({tag, ":count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("%s:data[%0d]", tag, i), 64'(got_q[i].d), 64'(exp_q[i].d));
            chk($sformatf("%s:last[%0d]", tag, i), 64'(got_q[i].l), 64'(exp_q[i].l));
            chk($sformatf("%s:user[%0d]", tag, i), 64'(got_q[i].u), 64'(exp_q[i].u));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_frames(input string tag);
        chk(tag, 64'(frame_cnt), 64'(16'(exp_frames)));
    endtask

    initial begin
        int basic_d[6];
        int basic_l[6];
        int sidx;
        vectors     = 0;
        miscompares = 0;
        exp_frames  = 0;
        basic_d     = '{10, 11, 12, 18, 19, 20};
        basic_l     = '{0, 0, 1, 0, 0, 1};
        rst_n       = 1'b0;
        s_tdata     = '0;
        s_tvalid    = 1'b0;
        s_tstrb     = '1;
        s_tlast     = 1'b0;
        s_tuser     = 1'b0;
        full        = 1'b0;
        cfg_x_start = '0;
        cfg_y_start = '0;
        cfg_width   = '0;
        cfg_height  = '0;

        // Reset values.
        #1;
        chk("rst_crop_active", 64'(crop_active), 64'(0));
        chk("rst_wr_en", 64'(wr_en), 64'(0));
        chk("rst_tready", 64'(s_tready), 64'(1));
        chk("rst_frame_cnt", 64'(frame_cnt), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic crop of an 8x4 frame.
        make_frame(4, 8, -1, 0, 1'b0, 2, 1, 3, 2, -1);
        play(-1, 0, 1'b0);
        exp_frames++;
        chk("basic_count", 64'(got_q.size()), 64'(6));
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            chk($sformatf("basic_const_data[%0d]", i), 64'(got_q[i].d), 64'(basic_d[i]));
            chk($sformatf("basic_const_last[%0d]", i), 64'(got_q[i].l), 64'(basic_l[i]));
        end
        compare("basic");
        chk_frames("basic_frame_cnt");
        chk("basic_crop_active", 64'(crop_active), 64'(1));

        // Backpressure on the beat at col 3, row 1.
        make_frame(4, 8, -1, 0, 1'b0, 2, 1, 3, 2, -1);
        play(11, 3, 1'b0);
        exp_frames++;
        compare("backpressure");
        chk_frames("backpressure_frame_cnt");

        // Short input line closes the cropped line early.
        make_frame(4, 8, 1, 4, 1'b0, 2, 1, 3, 2, -1);
        play(-1, 0, 1'b0);
        exp_frames++;
        compare("short_line");

        // Zero width produces nothing.
        make_frame(4, 8, -1, 0, 1'b0, 2, 1, 0, 2, -1);
        play(-1, 0, 1'b0);
        exp_frames++;
        chk("zero_width_count", 64'(got_q.size()), 64'(0));
        compare("zero_width");

        // Frame restarted mid row 2.
        make_frame(4, 8, -1, 0, 1'b0, 2, 1, 3, 2, 20);
        make_frame(4, 8, -1, 0, 1'b0, 2, 1, 3, 2, -1);
        play(-1, 0, 1'b0);
        exp_frames += 2;
        compare("resync");
        chk_frames("resync_frame_cnt");

        // Column saturation: beats past the last representable column are dropped.
        make_frame(1, 4100, -1, 0, 1'b1, 4090, 0, 10, 1, -1);
        play(-1, 0, 1'b0);
        exp_frames++;
        compare("saturate");

        // Random geometry, data, short lines, stalls and mid-frame config changes.
        for (int k = 0; k < 6; k++) begin
            int rows;
            int cols;
            rows = $urandom_range(1, 6);
            cols = $urandom_range(1, 10);
            make_frame(rows, cols, $urandom_range(0, rows - 1), $urandom_range(1, cols), 1'b1,
                       $urandom_range(0, 10), $urandom_range(0, 6),
                       $urandom_range(0, 6), $urandom_range(0, 4), -1);
            sidx = (stim.size() > 1) ? $urandom_range(1, stim.size() - 1) : -1;
            play(sidx, $urandom_range(1, 3), 1'b1);
            exp_frames++;
            compare($sformatf("random%0d", k));
        end
        chk_frames("random_frame_cnt");

        // Asynchronous reset during an in-window row-1 beat.
        make_frame(4, 8, -1, 0, 1'b0, 2, 1, 3, 2, -1);
        exp_q.delete();
        for (int i = 0; i < 10; i++) send(stim[i].d, stim[i].u, stim[i].l, 0);
        s_tdata  = stim[10].d;
        s_tuser  = stim[10].u;
        s_tlast  = stim[10].l;
        s_tvalid = 1'b1;
        #1;
        chk("prereset_wr_en", 64'(wr_en), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("midreset_wr_en", 64'(wr_en), 64'(0));
        chk("midreset_crop_active", 64'(crop_active), 64'(0));
        chk("midreset_frame_cnt", 64'(frame_cnt), 64'(0));
        chk("midreset_tready", 64'(s_tready), 64'(1));
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        rst_n    = 1'b1;
        exp_frames = 0;
        for (int i = 11; i < stim.size(); i++) send(stim[i].d, stim[i].u, stim[i].l, 0);
        stim.delete();
        compare("after_reset");
        chk("after_reset_crop_active", 64'(crop_active), 64'(0));
        chk_frames("after_reset_frame_cnt");

        // Beats before any start of frame are drained, then a normal frame.
        for (int i = 0; i < 5; i++) send($urandom, 1'b0, 1'($urandom_range(0, 1)), 0);
        chk("drain_count", 64'(got_q.size()), 64'(0));
        make_frame(4, 8, -1, 0, 1'b0, 2, 1, 3, 2, -1);
        play(-1, 0, 1'b0);
        exp_frames++;
        compare("drain_then_basic");
        chk_frames("drain_frame_cnt");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
